// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int PC_STEP = 4;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    VALID = 3'd3,
    FAULT = 3'd4
  } if_state_e;

endpackage

// File: rtl/if_perf_cnt.sv
// Fetch/stall event counters for the instruction-fetch stage; both wrap at 2^32.
module if_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_inc,
  input  logic        stall_inc,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_stall
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetch <= '0;
      perf_stall <= '0;
    end else begin
      if (fetch_inc) perf_fetch <= perf_fetch + 32'd1;
      if (stall_inc) perf_stall <= perf_stall + 32'd1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: req/ack fetch from imem into an IF/ID register.
// Optional performance counters are built when IF_PERF_CNT_EN is defined.
module instr_fetch
  import if_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_adv,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc4,
  output logic              fault
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch,
  output logic [31:0]       perf_stall
`endif
);

  if_state_e state, state_nxt;
  logic      load_addr;
  logic      capture;

  always_comb begin
    state_nxt = state;
    load_addr = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (!flush) begin
          if ((pc[1:0] & ALIGN_MASK) != 2'b00) begin
            state_nxt = FAULT;
          end else begin
            load_addr = 1'b1;
            state_nxt = FETCH;
          end
        end
      end
      FETCH: begin
        if (imem_ack) begin
          if (!flush) begin
            capture   = 1'b1;
            state_nxt = VALID;
          end else begin
            state_nxt = IDLE;
          end
        end else if (flush) begin
          state_nxt = DRAIN;
        end
      end
      // The abandoned request still owes us an ack; wait it out and drop the data.
      DRAIN: begin
        if (imem_ack) state_nxt = IDLE;
      end
      // Decode handshake: the word transfers on a cycle with id_valid & id_ready & !flush;
      // id_* hold stable while id_valid is high and id_ready is low.
      VALID: begin
        if (flush || id_ready) state_nxt = IDLE;
      end
      FAULT: state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
  end

  assign imem_req = (state == FETCH) || (state == DRAIN);
  assign pc_adv   = capture;
  assign id_valid = (state == VALID);
  assign fault    = (state == FAULT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      imem_addr <= '0;
      id_instr  <= '0;
      id_pc     <= '0;
      id_pc4    <= '0;
    end else begin
      state <= state_nxt;
      if (load_addr) imem_addr <= pc;
      if (capture) begin
        id_instr <= imem_rdata;
        id_pc    <= imem_addr;
        id_pc4   <= imem_addr + ADDR_W'(PC_STEP);
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic stall;

  assign stall = (((state == FETCH) || (state == DRAIN)) && !imem_ack) ||
                 ((state == VALID) && !id_ready);

  if_perf_cnt u_perf_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .fetch_inc  (pc_adv),
    .stall_inc  (stall),
    .perf_fetch (perf_fetch),
    .perf_stall (perf_stall)
  );
`endif

endmodule
